// File: rtl/ex_cond_unit.sv
// ex_cond_unit: execute-to-memory pipeline stage with conditional execution.
// Holds the architectural NZCV flag register, evaluates the instruction
// condition against it, squashes write/branch enables of failed instructions
// and keeps a saturating count of condition-failed instructions.
module ex_cond_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        valid_in,
   input  logic [3:0]  cond,
   input  logic [1:0]  flag_write,
   input  logic        aN,
   input  logic        aZ,
   input  logic        aC,
   input  logic        aV,
   input  logic [31:0] result_in,
   input  logic [3:0]  rd_in,
   input  logic        reg_write_in,
   input  logic        mem_write_in,
   input  logic        branch_in,
   input  logic        stall,
   input  logic        flush,
   output logic        valid_out,
   output logic [31:0] result_out,
   output logic [3:0]  rd_out,
   output logic        reg_write_out,
   output logic        mem_write_out,
   output logic        branch_taken,
   output logic [3:0]  flags,
   output logic [15:0] squash_cnt
);

   typedef enum logic [3:0] {
      CC_EQ = 4'h0, CC_NE = 4'h1, CC_CS = 4'h2, CC_CC = 4'h3,
      CC_MI = 4'h4, CC_PL = 4'h5, CC_VS = 4'h6, CC_VC = 4'h7,
      CC_HI = 4'h8, CC_LS = 4'h9, CC_GE = 4'hA, CC_LT = 4'hB,
      CC_GT = 4'hC, CC_LE = 4'hD, CC_AL = 4'hE, CC_NV = 4'hF
   } cond_e;

   logic        valid_q,     valid_d;
   logic [31:0] result_q,    result_d;
   logic [3:0]  rd_q,        rd_d;
   logic        reg_write_q, reg_write_d;
   logic        mem_write_q, mem_write_d;
   logic        branch_q,    branch_d;
   logic [3:0]  flags_q,     flags_d;
   logic [15:0] squash_q,    squash_d;

   cond_e cc;
   logic  fl_n, fl_z, fl_c, fl_v;
   logic  cond_ex;
   logic  fire;

   assign cc   = cond_e'(cond);
   assign fl_n = flags_q[3];
   assign fl_z = flags_q[2];
   assign fl_c = flags_q[1];
   assign fl_v = flags_q[0];

   // Condition check against the registered flags only (no a-flag bypass)
   always_comb begin
      cond_ex = 1'b1;
      case (cc)
         CC_EQ:   cond_ex = fl_z;
         CC_NE:   cond_ex = ~fl_z;
         CC_CS:   cond_ex = fl_c;
         CC_CC:   cond_ex = ~fl_c;
         CC_MI:   cond_ex = fl_n;
         CC_PL:   cond_ex = ~fl_n;
         CC_VS:   cond_ex = fl_v;
         CC_VC:   cond_ex = ~fl_v;
         CC_HI:   cond_ex = fl_c & ~fl_z;
         CC_LS:   cond_ex = ~fl_c | fl_z;
         CC_GE:   cond_ex = (fl_n == fl_v);
         CC_LT:   cond_ex = (fl_n != fl_v);
         CC_GT:   cond_ex = ~fl_z & (fl_n == fl_v);
         CC_LE:   cond_ex = fl_z | (fl_n != fl_v);
         CC_AL:   cond_ex = 1'b1;
         CC_NV:   cond_ex = 1'b1;
         default: cond_ex = 1'b1;
      endcase
   end

   assign fire = valid_in & cond_ex & ~stall & ~flush;

   // Next-state: flush beats stall; stall holds everything; otherwise advance
   always_comb begin
      valid_d     = valid_q;
      result_d    = result_q;
      rd_d        = rd_q;
      reg_write_d = reg_write_q;
      mem_write_d = mem_write_q;
      branch_d    = branch_q;
      flags_d     = flags_q;
      squash_d    = squash_q;
      if (flush) begin
         valid_d     = 1'b0;
         reg_write_d = 1'b0;
         mem_write_d = 1'b0;
         branch_d    = 1'b0;
      end else if (!stall) begin
         valid_d     = valid_in;
         result_d    = result_in;
         rd_d        = rd_in;
         reg_write_d = reg_write_in & fire;
         mem_write_d = mem_write_in & fire;
         branch_d    = branch_in & fire;
         if (fire && flag_write[1]) flags_d[3:2] = {aN, aZ};
         if (fire && flag_write[0]) flags_d[1:0] = {aC, aV};
         if (valid_in && !cond_ex && (squash_q != '1))
            squash_d = squash_q + 16'd1;
      end
   end

   // State register with synchronous reset overriding all other controls
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q     <= 1'b0;
         result_q    <= '0;
         rd_q        <= '0;
         reg_write_q <= 1'b0;
         mem_write_q <= 1'b0;
         branch_q    <= 1'b0;
         flags_q     <= '0;
         squash_q    <= '0;
      end else begin
         valid_q     <= valid_d;
         result_q    <= result_d;
         rd_q        <= rd_d;
         reg_write_q <= reg_write_d;
         mem_write_q <= mem_write_d;
         branch_q    <= branch_d;
         flags_q     <= flags_d;
         squash_q    <= squash_d;
      end
   end

   assign valid_out     = valid_q;
   assign result_out    = result_q;
   assign rd_out        = rd_q;
   assign reg_write_out = reg_write_q;
   assign mem_write_out = mem_write_q;
   assign branch_taken  = branch_q;
   assign flags         = flags_q;
   assign squash_cnt    = squash_q;

endmodule

// File: tb/tb_ex_cond_unit.sv
// Bench for ex_cond_unit: directed vector table, random run against a
// behavioural model, and a long squash-counter saturation sequence.
module tb_ex_cond_unit;

   logic        clk;
   logic        reset;
   logic        valid_in;
   logic [3:0]  cond;
   logic [1:0]  flag_write;
   logic        aN, aZ, aC, aV;
   logic [31:0] result_in;
   logic [3:0]  rd_in;
   logic        reg_write_in, mem_write_in, branch_in;
   logic        stall, flush;
   logic        valid_out;
   logic [31:0] result_out;
   logic [3:0]  rd_out;
   logic        reg_write_out, mem_write_out, branch_taken;
   logic [3:0]  flags;
   logic [15:0] squash_cnt;

   int checks;
   int failures;

   ex_cond_unit dut (
      .clk(clk), .reset(reset), .valid_in(valid_in), .cond(cond),
      .flag_write(flag_write), .aN(aN), .aZ(aZ), .aC(aC), .aV(aV),
      .result_in(result_in), .rd_in(rd_in), .reg_write_in(reg_write_in),
      .mem_write_in(mem_write_in), .branch_in(branch_in), .stall(stall),
      .flush(flush), .valid_out(valid_out), .result_out(result_out),
      .rd_out(rd_out), .reg_write_out(reg_write_out),
      .mem_write_out(mem_write_out), .branch_taken(branch_taken),
      .flags(flags), .squash_cnt(squash_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   bit          m_vo, m_rw, m_mw, m_br, m_res_known;
   logic [31:0] m_res;
   logic [3:0]  m_rd;
   logic [3:0]  m_fl;
   int unsigned m_cnt;

   function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
      bit n, z, cy, v, signed_lt;
      n = f[3]; z = f[2]; cy = f[1]; v = f[0];
      signed_lt = (n ^ v);
      case (c)
         4'd0:  return z;
         4'd1:  return !z;
         4'd2:  return cy;
         4'd3:  return !cy;
         4'd4:  return n;
         4'd5:  return !n;
         4'd6:  return v;
         4'd7:  return !v;
         4'd8:  return cy && !z;
         4'd9:  return !cy || z;
         4'd10: return !signed_lt;
         4'd11: return signed_lt;
         4'd12: return !z && !signed_lt;
         4'd13: return z || signed_lt;
         default: return 1'b1;
      endcase
   endfunction

   task automatic model_update();
      bit pass, f;
      if (reset) begin
         m_vo = 0; m_rw = 0; m_mw = 0; m_br = 0;
         m_res = '0; m_rd = '0; m_fl = '0; m_cnt = 0; m_res_known = 1;
      end else if (flush) begin
         m_vo = 0; m_rw = 0; m_mw = 0; m_br = 0; m_res_known = 0;
      end else if (!stall) begin
         pass = cond_ok(cond, m_fl);
         f = valid_in && pass;
         m_vo = valid_in; m_res = result_in; m_rd = rd_in; m_res_known = 1;
         m_rw = reg_write_in && f;
         m_mw = mem_write_in && f;
         m_br = branch_in && f;
         if (f && flag_write[1]) begin m_fl[3] = aN; m_fl[2] = aZ; end
         if (f && flag_write[0]) begin m_fl[1] = aC; m_fl[0] = aV; end
         if (valid_in && !pass && m_cnt < 65535) m_cnt = m_cnt + 1;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
      end
   endtask

   task automatic compare_model();
      chk("model.valid_out", {31'd0, valid_out}, {31'd0, m_vo});
      chk("model.reg_write_out", {31'd0, reg_write_out}, {31'd0, m_rw});
      chk("model.mem_write_out", {31'd0, mem_write_out}, {31'd0, m_mw});
      chk("model.branch_taken", {31'd0, branch_taken}, {31'd0, m_br});
      chk("model.flags", {28'd0, flags}, {28'd0, m_fl});
      chk("model.squash_cnt", {16'd0, squash_cnt}, m_cnt);
      if (m_res_known) begin
         chk("model.result_out", result_out, m_res);
         chk("model.rd_out", {28'd0, rd_out}, {28'd0, m_rd});
      end
   endtask

   task automatic step();
      model_update();
      @(posedge clk);
      #1;
      compare_model();
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic        rst, v;
      logic [3:0]  cnd;
      logic [1:0]  fw;
      logic [3:0]  af;
      logic [31:0] res;
      logic        rw, mw, br, st, fl;
      logic        evo, erw, emw, ebr;
      logic [3:0]  ef;
      logic [15:0] ecnt;
      logic        chkres;
      logic [31:0] eres;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(
      input logic rst, input logic v, input logic [3:0] cnd, input logic [1:0] fw,
      input logic [3:0] af, input logic [31:0] res, input logic rw, input logic mw,
      input logic br, input logic st, input logic fl,
      input logic evo, input logic erw, input logic emw, input logic ebr,
      input logic [3:0] ef, input logic [15:0] ecnt, input logic chkres,
      input logic [31:0] eres);
      vec_t r;
      r.rst = rst; r.v = v; r.cnd = cnd; r.fw = fw; r.af = af; r.res = res;
      r.rw = rw; r.mw = mw; r.br = br; r.st = st; r.fl = fl;
      r.evo = evo; r.erw = erw; r.emw = emw; r.ebr = ebr;
      r.ef = ef; r.ecnt = ecnt; r.chkres = chkres; r.eres = eres;
      return r;
   endfunction

   task automatic drive(input logic rst, input logic v, input logic [3:0] cnd,
                        input logic [1:0] fw, input logic [3:0] af, input logic [31:0] res,
                        input logic [3:0] rd, input logic rw, input logic mw,
                        input logic br, input logic st, input logic fl);
      reset = rst; valid_in = v; cond = cnd; flag_write = fw;
      {aN, aZ, aC, aV} = af; result_in = res; rd_in = rd;
      reg_write_in = rw; mem_write_in = mw; branch_in = br;
      stall = st; flush = fl;
   endtask

   initial begin
      checks = 0;
      failures = 0;
      drive(1'b1, 1'b0, 4'h0, 2'b00, 4'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      //              rst v  cnd    fw     af       res           rw mw br st fl  vo rw mw br  flags   cnt     cr eres
      tbl.push_back(mk(1, 0, 4'h0, 2'b00, 4'b0000, 32'h0,        0, 0, 0, 0, 0,  0, 0, 0, 0, 4'b0000, 16'd0, 1, 32'h0));
      tbl.push_back(mk(0, 1, 4'h0, 2'b00, 4'b0000, 32'hAAAA,     1, 0, 0, 0, 0,  1, 0, 0, 0, 4'b0000, 16'd1, 1, 32'hAAAA));
      tbl.push_back(mk(0, 1, 4'h1, 2'b00, 4'b0000, 32'hBBBB,     1, 0, 0, 0, 0,  1, 1, 0, 0, 4'b0000, 16'd1, 1, 32'hBBBB));
      tbl.push_back(mk(0, 1, 4'hE, 2'b11, 4'b0100, 32'h0,        0, 0, 0, 0, 0,  1, 0, 0, 0, 4'b0100, 16'd1, 1, 32'h0));
      tbl.push_back(mk(0, 1, 4'h0, 2'b00, 4'b0000, 32'h5,        1, 0, 0, 0, 0,  1, 1, 0, 0, 4'b0100, 16'd1, 1, 32'h5));
      tbl.push_back(mk(0, 1, 4'h1, 2'b11, 4'b1111, 32'h1234,     1, 1, 0, 0, 0,  1, 0, 0, 0, 4'b0100, 16'd2, 1, 32'h1234));
      tbl.push_back(mk(0, 1, 4'hE, 2'b11, 4'b1000, 32'h6,        0, 0, 0, 0, 0,  1, 0, 0, 0, 4'b1000, 16'd2, 1, 32'h6));
      tbl.push_back(mk(0, 1, 4'hB, 2'b00, 4'b0000, 32'h7,        0, 0, 1, 0, 0,  1, 0, 0, 1, 4'b1000, 16'd2, 1, 32'h7));
      tbl.push_back(mk(0, 0, 4'hB, 2'b00, 4'b0000, 32'h8,        1, 1, 1, 0, 0,  0, 0, 0, 0, 4'b1000, 16'd2, 1, 32'h8));
      tbl.push_back(mk(0, 1, 4'hA, 2'b00, 4'b0000, 32'h99,       0, 0, 1, 0, 0,  1, 0, 0, 0, 4'b1000, 16'd3, 1, 32'h99));
      tbl.push_back(mk(0, 1, 4'hE, 2'b11, 4'b0010, 32'h77,       1, 0, 0, 1, 0,  1, 0, 0, 0, 4'b1000, 16'd3, 1, 32'h99));
      tbl.push_back(mk(0, 1, 4'hE, 2'b11, 4'b0010, 32'h77,       1, 0, 0, 1, 0,  1, 0, 0, 0, 4'b1000, 16'd3, 1, 32'h99));
      tbl.push_back(mk(0, 1, 4'hE, 2'b11, 4'b0010, 32'h77,       1, 0, 0, 1, 0,  1, 0, 0, 0, 4'b1000, 16'd3, 1, 32'h99));
      tbl.push_back(mk(0, 1, 4'hE, 2'b11, 4'b0010, 32'h77,       1, 0, 0, 1, 1,  0, 0, 0, 0, 4'b1000, 16'd3, 0, 32'h0));
      tbl.push_back(mk(0, 1, 4'hB, 2'b00, 4'b0000, 32'h14,       0, 0, 1, 0, 0,  1, 0, 0, 1, 4'b1000, 16'd3, 1, 32'h14));
      tbl.push_back(mk(0, 1, 4'hA, 2'b00, 4'b0000, 32'h15,       0, 0, 1, 1, 0,  1, 0, 0, 1, 4'b1000, 16'd3, 1, 32'h14));
      tbl.push_back(mk(0, 0, 4'hB, 2'b00, 4'b0000, 32'h16,       0, 0, 1, 0, 0,  0, 0, 0, 0, 4'b1000, 16'd3, 1, 32'h16));
      tbl.push_back(mk(0, 1, 4'hE, 2'b11, 4'b1111, 32'h17,       1, 0, 0, 0, 0,  1, 1, 0, 0, 4'b1111, 16'd3, 1, 32'h17));
      tbl.push_back(mk(0, 1, 4'hE, 2'b11, 4'b0000, 32'h18,       1, 0, 0, 1, 0,  1, 1, 0, 0, 4'b1111, 16'd3, 1, 32'h17));
      tbl.push_back(mk(1, 1, 4'hE, 2'b11, 4'b0000, 32'h19,       1, 1, 1, 1, 0,  0, 0, 0, 0, 4'b0000, 16'd0, 1, 32'h0));
      tbl.push_back(mk(0, 1, 4'h0, 2'b00, 4'b0000, 32'h20,       1, 0, 0, 0, 0,  1, 0, 0, 0, 4'b0000, 16'd1, 1, 32'h20));
      tbl.push_back(mk(0, 1, 4'hE, 2'b11, 4'b0100, 32'h21,       1, 1, 1, 0, 1,  0, 0, 0, 0, 4'b0000, 16'd1, 0, 32'h0));
      tbl.push_back(mk(0, 1, 4'h0, 2'b00, 4'b0000, 32'h22,       1, 0, 0, 0, 0,  1, 0, 0, 0, 4'b0000, 16'd2, 1, 32'h22));

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].rst, tbl[i].v, tbl[i].cnd, tbl[i].fw, tbl[i].af, tbl[i].res,
               4'(i), tbl[i].rw, tbl[i].mw, tbl[i].br, tbl[i].st, tbl[i].fl);
         step();
         chk($sformatf("vec%0d.valid_out", i), {31'd0, valid_out}, {31'd0, tbl[i].evo});
         chk($sformatf("vec%0d.reg_write_out", i), {31'd0, reg_write_out}, {31'd0, tbl[i].erw});
         chk($sformatf("vec%0d.mem_write_out", i), {31'd0, mem_write_out}, {31'd0, tbl[i].emw});
         chk($sformatf("vec%0d.branch_taken", i), {31'd0, branch_taken}, {31'd0, tbl[i].ebr});
         chk($sformatf("vec%0d.flags", i), {28'd0, flags}, {28'd0, tbl[i].ef});
         chk($sformatf("vec%0d.squash_cnt", i), {16'd0, squash_cnt}, {16'd0, tbl[i].ecnt});
         if (tbl[i].chkres)
            chk($sformatf("vec%0d.result_out", i), result_out, tbl[i].eres);
      end

      // Random run against the model
      for (int i = 0; i < 3000; i++) begin
         drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
               4'($urandom), 2'($urandom), 4'($urandom), $urandom, 4'($urandom),
               1'($urandom), 1'($urandom), 1'($urandom),
               ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0));
         step();
      end

      // Saturation: fill to FFFD with failing EQ (flags stay 0000), then cross the top
      drive(1'b1, 1'b0, 4'h0, 2'b00, 4'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      drive(1'b0, 1'b1, 4'h0, 2'b00, 4'h0, 32'hC0DE, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 65533; i++) step();
      chk("sat.pre", {16'd0, squash_cnt}, 32'h0000FFFD);
      step();
      chk("sat.fffe", {16'd0, squash_cnt}, 32'h0000FFFE);
      step();
      chk("sat.ffff", {16'd0, squash_cnt}, 32'h0000FFFF);
      step();
      step();
      chk("sat.hold", {16'd0, squash_cnt}, 32'h0000FFFF);
      chk("sat.reg_write_out", {31'd0, reg_write_out}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ex_cond_unit.md
EX_COND_UNIT -- requirements
Module: ex_cond_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk input 1, rising-edge clock; reset input 1, synchronous active-high reset.
REQ-002 The block SHALL have these inputs: valid_in input 1, execute-stage instruction valid; cond input 4, instruction condition field.
REQ-003 The block SHALL have these inputs: flag_write input 2, where bit1 updates N,Z and bit0 updates C,V; aN/aZ/aC/aV input 1 each, ALU flags of the current instruction.
REQ-004 The block SHALL have these inputs: result_in input 32, ALU result; rd_in input 4, destination register; reg_write_in/mem_write_in/branch_in input 1 each, decoded controls.
REQ-005 The block SHALL have these inputs: stall input 1, hold the stage; flush input 1, kill the stage.
REQ-006 The block SHALL have these outputs: valid_out output 1; result_out output 32; rd_out output 4; reg_write_out/mem_write_out output 1 each; branch_taken output 1; all registered.
REQ-007 The block SHALL have these outputs: flags output 4, live flag register {N,Z,C,V}; squash_cnt output 16, saturating count of condition-failed instructions.

Function
REQ-008 The block SHALL sit directly downstream of the ALU; it is the execute-to-memory stage and holds the architectural flag register.
REQ-009 cond_ex SHALL be evaluated combinationally from the flag register, not from the incoming a-flags, as follows.
- 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C.
- 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V.
- 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V.
- 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 and 1111 always true.
- 1111 is treated as always.
- Define fire = valid_in & cond_ex & !stall & !flush.
REQ-010 On a clock edge with fire=1, flags[3:2] SHALL load {aN,aZ} if flag_write[1], and flags[1:0] SHALL load {aC,aV} if flag_write[0]; otherwise the flags hold.
REQ-011 The flag update SHALL be visible to the next instruction's condition one cycle later; no bypass from a-flags SHALL exist.
REQ-012 Pipeline register, no stall/flush: valid_out <= valid_in; result_out <= result_in; rd_out <= rd_in.
REQ-013 Pipeline register, no stall/flush: reg_write_out <= reg_write_in & fire; mem_write_out <= mem_write_in & fire; branch_taken <= branch_in & fire.
REQ-014 Latency from inputs to registered outputs SHALL be exactly 1 cycle.
REQ-015 result_out and rd_out SHALL be loaded even when the condition fails; only the write/branch enables are squashed.
REQ-016 On stall=1 and flush=0, all pipeline outputs, flags and squash_cnt SHALL hold their values.
REQ-017 On flush=1, flush SHALL win over stall.
- valid_out, reg_write_out, mem_write_out and branch_taken SHALL be cleared at the next edge.
- result_out and rd_out are don't-care.
- flags and squash_cnt SHALL hold.
REQ-018 squash_cnt SHALL increment by 1 on each edge with valid_in & !cond_ex & !stall & !flush.
REQ-019 squash_cnt SHALL saturate at 16'hFFFF and SHALL NOT wrap.
REQ-020 branch_taken SHALL be a 1-cycle pulse per taken branch, unless the stage is stalled, in which case it holds.
REQ-021 With valid_in=0, no flag update, squash count or enable SHALL occur; valid_out SHALL become 0.

Reset
REQ-022 reset SHALL take priority over flush, stall and all inputs.
REQ-023 On the reset edge, valid_out, reg_write_out, mem_write_out and branch_taken SHALL be 0.
REQ-024 On the reset edge, result_out=32'h0, rd_out=4'h0, flags=4'b0000 and squash_cnt=16'h0.
REQ-025 Reset asserted mid-operation, including during a stall, SHALL discard the in-flight instruction, with no flag update and no enable.
REQ-026 After reset deasserts, the first valid instruction SHALL be evaluated against flags=0000, so EQ fails and NE passes.

Verification
REQ-027 SUBS sets Z: valid_in=1, cond=1110, flag_write=11, aZ=1, others 0, result_in=0.
- Next cycle: flags=0100, valid_out=1.
- Following instruction cond=0000, reg_write_in=1: reg_write_out=1 one cycle later.
REQ-028 Condition fail: flags=0100, cond=0001, reg_write_in=1, mem_write_in=1, result_in=32'h1234, flag_write=11 with a-flags 1111.
- Response: reg_write_out=0, mem_write_out=0, result_out=32'h1234.
- flags stay 0100 and squash_cnt increments by 1.
REQ-029 Signed compare: flags set to N=1, V=0.
- cond=1011 LT with branch_in=1: branch_taken=1 for one cycle.
- cond=1010 GE: branch_taken=0 and squash_cnt+1.
REQ-030 Stall/flush priority: with a valid ADDS (flag_write=11, aC=1) presented, stall=1 for 3 cycles.
- Outputs and flags hold.
- Then stall=1 and flush=1 together: valid_out=0 and flags unchanged, because the instruction is killed.
REQ-031 Saturation: preload squash_cnt to 16'hFFFE via 2 further failed instructions; squash_cnt SHALL read 16'hFFFF and stay there.
REQ-032 Reset mid-stall: flags=1111 and a stalled valid instruction present; reset=1 for one edge.
- All outputs SHALL be zero/default, with flags=0000 and squash_cnt=0.
